// File: rtl/ledstrip_text_sequencer.sv
// Character-bitmap sequencer for the LED-strip text path: fetches 5x7 glyphs from a
// combinational ROM and streams them column by column over a valid/ready handshake.
module ledstrip_text_sequencer #(
    parameter int unsigned MSG_LEN  = 8,
    parameter int unsigned COLS     = 5,
    parameter int unsigned ROWS     = 7,
    parameter int unsigned GAP_COLS = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         msg_we_i,
    input  logic [$clog2(MSG_LEN)-1:0]   msg_waddr_i,
    input  logic [6:0]                   msg_wdata_i,
    input  logic [$clog2(MSG_LEN):0]     msg_len_i,
    input  logic                         start_i,
    input  logic                         loop_i,
    input  logic                         stop_i,
    output logic [6:0]                   rom_addr_o,
    input  logic [ROWS*COLS-1:0]         rom_data_i,
    output logic                         col_valid_o,
    input  logic                         col_ready_i,
    output logic [ROWS-1:0]              col_data_o,
    output logic                         col_last_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int unsigned AW      = $clog2(MSG_LEN);
    localparam int unsigned LW      = AW + 1;
    localparam int unsigned CIW     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned GW      = (GAP_COLS > 1) ? $clog2(GAP_COLS) : 1;
    localparam int unsigned GapLast = (GAP_COLS > 0) ? GAP_COLS - 1 : 0;

    typedef enum logic [1:0] {StIdle, StFetch, StEmit, StGap} state_e;

    state_e               state_q, state_d;
    logic [LW-1:0]        len_q, len_d;
    logic [AW-1:0]        char_idx_q, char_idx_d;
    logic [CIW-1:0]       col_idx_q, col_idx_d;
    logic [GW-1:0]        gap_idx_q, gap_idx_d;
    logic [ROWS*COLS-1:0] glyph_q, glyph_d;
    logic [6:0]           rom_addr_q, rom_addr_d;
    logic                 done_q, done_d;
    logic [6:0]           msg_q [MSG_LEN];

    logic                 handshake;
    logic                 last_char;
    logic                 end_of_char;
    logic                 len_ok;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_q[i] <= 7'h20;
            end
        end else if (msg_we_i) begin
            msg_q[msg_waddr_i] <= msg_wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            len_q      <= '0;
            char_idx_q <= '0;
            col_idx_q  <= '0;
            gap_idx_q  <= '0;
            glyph_q    <= '0;
            rom_addr_q <= 7'h20;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            char_idx_q <= char_idx_d;
            col_idx_q  <= col_idx_d;
            gap_idx_q  <= gap_idx_d;
            glyph_q    <= glyph_d;
            rom_addr_q <= rom_addr_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        char_idx_d  = char_idx_q;
        col_idx_d   = col_idx_q;
        gap_idx_d   = gap_idx_q;
        glyph_d     = glyph_q;
        rom_addr_d  = rom_addr_q;
        done_d      = 1'b0;
        end_of_char = 1'b0;

        col_valid_o = (state_q == StEmit) || (state_q == StGap);
        handshake   = col_valid_o && col_ready_i;
        last_char   = ({1'b0, char_idx_q} == (len_q - LW'(1)));
        len_ok      = (msg_len_i != '0) && (msg_len_i <= LW'(MSG_LEN));

        // ROM is combinational, so the address must be live during the fetch cycle itself.
        rom_addr_o  = (state_q == StFetch) ? msg_q[char_idx_q] : rom_addr_q;
        col_data_o  = (state_q == StEmit) ? glyph_q[col_idx_q*ROWS +: ROWS] : '0;
        busy_o      = (state_q != StIdle);
        done_o      = done_q;
        if (GAP_COLS > 0) begin
            col_last_o = last_char && (state_q == StGap) && (gap_idx_q == GW'(GapLast));
        end else begin
            col_last_o = last_char && (state_q == StEmit) && (col_idx_q == CIW'(COLS - 1));
        end

        unique case (state_q)
            StIdle: begin
                if (start_i && len_ok) begin
                    len_d      = msg_len_i;
                    char_idx_d = '0;
                    state_d    = StFetch;
                end
            end
            StFetch: begin
                glyph_d    = rom_data_i;
                rom_addr_d = rom_addr_o;
                col_idx_d  = '0;
                gap_idx_d  = '0;
                state_d    = StEmit;
            end
            StEmit: begin
                if (handshake) begin
                    if (col_idx_q == CIW'(COLS - 1)) begin
                        if (GAP_COLS > 0) begin
                            gap_idx_d = '0;
                            state_d   = StGap;
                        end else begin
                            end_of_char = 1'b1;
                        end
                    end else begin
                        col_idx_d = col_idx_q + CIW'(1);
                    end
                end
            end
            StGap: begin
                if (handshake) begin
                    if (gap_idx_q == GW'(GapLast)) begin
                        end_of_char = 1'b1;
                    end else begin
                        gap_idx_d = gap_idx_q + GW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (end_of_char) begin
            if (!last_char) begin
                char_idx_d = char_idx_q + AW'(1);
                state_d    = StFetch;
            end else begin
                done_d = 1'b1;
                if (loop_i) begin
                    char_idx_d = '0;
                    state_d    = StFetch;
                end else begin
                    state_d = StIdle;
                end
            end
        end

        // Abort wins over everything, including a same-cycle start or end of pass.
        if (stop_i) begin
            state_d = StIdle;
            done_d  = 1'b0;
        end
    end

endmodule

// File: tb/tb_ledstrip_text_sequencer.sv
// Directed bench for ledstrip_text_sequencer; the ROM model repeats the code in every column.
module tb_ledstrip_text_sequencer;

    localparam int unsigned MSG_LEN = 8;
    localparam int unsigned COLS    = 5;
    localparam int unsigned ROWS    = 7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        msg_we;
    logic [2:0]  msg_waddr;
    logic [6:0]  msg_wdata;
    logic [3:0]  msg_len;
    logic        start, loop_en, stop;
    logic [6:0]  rom_addr;
    logic [34:0] rom_data;
    logic        col_valid, col_ready, col_last, busy, done;
    logic [6:0]  col_data;

    always #5 clk = ~clk;
    assign rom_data = {COLS{rom_addr}};

    ledstrip_text_sequencer #(
        .MSG_LEN (MSG_LEN),
        .COLS    (COLS),
        .ROWS    (ROWS),
        .GAP_COLS(1)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .msg_we_i   (msg_we),
        .msg_waddr_i(msg_waddr),
        .msg_wdata_i(msg_wdata),
        .msg_len_i  (msg_len),
        .start_i    (start),
        .loop_i     (loop_en),
        .stop_i     (stop),
        .rom_addr_o (rom_addr),
        .rom_data_i (rom_data),
        .col_valid_o(col_valid),
        .col_ready_i(col_ready),
        .col_data_o (col_data),
        .col_last_o (col_last),
        .busy_o     (busy),
        .done_o     (done)
    );

    typedef struct {
        logic       ready;
        logic       valid;
        logic [6:0] data;
        logic       last;
        logic       done;
        logic       busy;
        logic [6:0] rom;
    } vec_t;

    vec_t       vecs [16];
    int         n_chk  = 0;
    int         n_fail = 0;
    logic [6:0] got_q  [$];
    logic       last_q [$];
    logic [6:0] exp_q  [$];
    bit         saw_done;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic v, input logic [6:0] d,
                                input logic l, input logic dn, input logic b,
                                input logic [6:0] ra);
        vec_t x;
        x.ready = r; x.valid = v; x.data = d; x.last = l; x.done = dn; x.busy = b; x.rom = ra;
        return x;
    endfunction

    // Expected pass: each code expands to five glyph columns plus one blank gap column.
    task automatic build_exp(input logic [6:0] c0, input logic [6:0] c1, input bit two);
        exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back(c0);
        exp_q.push_back(7'h00);
        if (two) begin
            for (int i = 0; i < 5; i++) exp_q.push_back(c1);
            exp_q.push_back(7'h00);
        end
    endtask

    task automatic collect(input int max_cyc, input bit toggle);
        logic [6:0] pd;
        bit pv, pr;
        pv = 0; pr = 1; pd = '0;
        saw_done = 0;
        got_q.delete();
        last_q.delete();
        for (int c = 0; c < max_cyc; c++) begin
            col_ready = toggle ? (c % 2 == 0) : 1'b1;
            if (col_valid && pv && !pr) chk("stall_hold_data", col_data, pd);
            if (col_valid && col_ready) begin
                got_q.push_back(col_data);
                last_q.push_back(col_last);
            end
            if (done) begin
                saw_done = 1;
                break;
            end
            pv = col_valid; pr = col_ready; pd = col_data;
            tick();
        end
        col_ready = 1'b1;
        chk("done_within_budget", saw_done, 1);
    endtask

    task automatic check_cols(input string name);
        int n;
        chk({name, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({name, "_data"}, got_q[i], exp_q[i]);
            chk({name, "_last"}, last_q[i], (i == exp_q.size() - 1) ? 1 : 0);
        end
    endtask

    task automatic kick(input logic [3:0] len);
        msg_len = len;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [6:0] d);
        msg_we = 1'b1; msg_waddr = a; msg_wdata = d;
        tick();
        msg_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; msg_we = 0; msg_waddr = 0; msg_wdata = 0; msg_len = 0;
        start = 0; loop_en = 0; stop = 0; col_ready = 1;
        tick(); tick();
        chk("rst_rom_addr", rom_addr, 7'h20);
        chk("rst_valid", col_valid, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // Test 1: cycle-exact table for "HI", len 2, ready held high.
        vecs[0] = mk(1, 0, 7'h00, 0, 0, 1, 7'h48);
        for (int i = 1; i <= 5; i++) vecs[i] = mk(1, 1, 7'h48, 0, 0, 1, 7'h48);
        vecs[6] = mk(1, 1, 7'h00, 0, 0, 1, 7'h48);
        vecs[7] = mk(1, 0, 7'h00, 0, 0, 1, 7'h49);
        for (int i = 8; i <= 12; i++) vecs[i] = mk(1, 1, 7'h49, 0, 0, 1, 7'h49);
        vecs[13] = mk(1, 1, 7'h00, 1, 0, 1, 7'h49);
        vecs[14] = mk(1, 0, 7'h00, 0, 1, 0, 7'h49);
        vecs[15] = mk(1, 0, 7'h00, 0, 0, 0, 7'h49);
        wr(3'd0, 7'h48);
        wr(3'd1, 7'h49);
        chk("idle_before_start", busy, 0);
        kick(4'd2);
        for (int i = 0; i < 16; i++) begin
            col_ready = vecs[i].ready;
            chk($sformatf("t1_valid[%0d]", i), col_valid, vecs[i].valid);
            if (vecs[i].valid) begin
                chk($sformatf("t1_data[%0d]", i), col_data, vecs[i].data);
                chk($sformatf("t1_last[%0d]", i), col_last, vecs[i].last);
            end
            chk($sformatf("t1_done[%0d]", i), done, vecs[i].done);
            chk($sformatf("t1_busy[%0d]", i), busy, vecs[i].busy);
            chk($sformatf("t1_rom[%0d]", i), rom_addr, vecs[i].rom);
            tick();
        end

        // Test 3: looping replays char 0 right after the done pulse.
        loop_en = 1'b1;
        kick(4'd2);
        collect(60, 0);
        build_exp(7'h48, 7'h49, 1);
        check_cols("loop_pass1");
        chk("loop_busy_at_done", busy, 1);
        chk("loop_bubble_valid", col_valid, 0);
        tick();
        chk("loop_col13_valid", col_valid, 1);
        chk("loop_col13_data", col_data, 7'h48);
        loop_en = 1'b0;
        collect(60, 0);
        check_cols("loop_pass2");
        chk("loop_end_busy", busy, 0);

        // Test 4: stop during the third column.
        tick();
        kick(4'd2);
        tick(); tick(); tick();
        chk("stop_pre_data", col_data, 7'h48);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_valid", col_valid, 0);
        chk("stop_busy", busy, 0);
        chk("stop_done", done, 0);
        tick();
        chk("stop_done_late", done, 0);
        chk("stop_still_idle", busy, 0);
        kick(4'd2);
        collect(60, 0);
        check_cols("stop_replay");

        // Test 5: invalid lengths ignored; start while busy ignored; late buffer write seen.
        tick();
        kick(4'd0);
        chk("len0_ignored", busy, 0);
        kick(4'd9);
        chk("len9_ignored", busy, 0);
        kick(4'd2);
        col_ready = 1'b0;
        tick();
        chk("t5_emit_char0", col_data, 7'h48);
        msg_we = 1'b1; msg_waddr = 3'd1; msg_wdata = 7'h5A;
        start = 1'b1; msg_len = 4'd1;
        tick();
        msg_we = 1'b0; start = 1'b0; msg_len = 4'd2;
        collect(60, 0);
        build_exp(7'h48, 7'h5A, 1);
        check_cols("t5_late_write");

        // Test 2: single 'A' with ready toggling every cycle.
        tick();
        wr(3'd0, 7'h41);
        kick(4'd1);
        collect(60, 1);
        build_exp(7'h41, 7'h00, 0);
        check_cols("t2_stall");

        // Test 6: asynchronous reset mid-emit clears outputs and buffer.
        tick();
        kick(4'd2);
        tick(); tick();
        chk("t6_pre_valid", col_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", col_valid, 0);
        chk("t6_data", col_data, 0);
        chk("t6_last", col_last, 0);
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_rom", rom_addr, 7'h20);
        tick();
        rst_n = 1'b1;
        tick();
        kick(4'd2);
        collect(60, 0);
        build_exp(7'h20, 7'h20, 1);
        check_cols("t6_cleared");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
